// File: rtl/p_div_pkg.sv
// Shared types and lane helpers for the packed divider: FSM states, lane-width
// codes, and the per-lane mask functions used by the datapath and subtractor.
package p_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        LW_32 = 3'd0,
        LW_16 = 3'd1,
        LW_8  = 3'd2,
        LW_4  = 3'd3,
        LW_2  = 3'd4
    } lane_e;

    localparam int unsigned PW_32 = 0;
    localparam int unsigned PW_16 = 1;
    localparam int unsigned PW_8  = 2;
    localparam int unsigned PW_4  = 3;
    localparam int unsigned PW_2  = 4;

    localparam logic [5:0] W_32 = 6'd32;
    localparam logic [5:0] W_16 = 6'd16;
    localparam logic [5:0] W_8  = 6'd8;
    localparam logic [5:0] W_4  = 6'd4;
    localparam logic [5:0] W_2  = 6'd2;

    // Anything that is not exactly one-hot runs as a single 32-bit lane.
    function automatic lane_e decode_pw(input logic [4:0] pw);
        lane_e lw;
        case (pw)
            5'b00001: lw = LW_32;
            5'b00010: lw = LW_16;
            5'b00100: lw = LW_8;
            5'b01000: lw = LW_4;
            5'b10000: lw = LW_2;
            default:  lw = LW_32;
        endcase
        return lw;
    endfunction

    function automatic logic [5:0] lane_bits(input lane_e lw);
        logic [5:0] w;
        case (lw)
            LW_32:   w = W_32;
            LW_16:   w = W_16;
            LW_8:    w = W_8;
            LW_4:    w = W_4;
            LW_2:    w = W_2;
            default: w = W_32;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] lane_lsb_mask(input logic [5:0] w);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m[i] = ((6'(i) & (w - 6'd1)) == 6'd0);
        end
        return m;
    endfunction

    function automatic logic [31:0] lane_msb_mask(input logic [5:0] w);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m[i] = ((6'(i) & (w - 6'd1)) == (w - 6'd1));
        end
        return m;
    endfunction

    // Copies the flag found at each lane's MSB position across the whole lane.
    function automatic logic [31:0] lane_spread(input logic [31:0] flags, input logic [5:0] w);
        logic [31:0] s;
        logic [5:0]  base;
        logic [4:0]  idx;
        s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            base = 6'(i) & ~(w - 6'd1);
            idx  = 5'(base + w - 6'd1);
            s[i] = flags[idx];
        end
        return s;
    endfunction

endpackage

// File: rtl/p_div_if.sv
// Requester/responder bundle for the packed divider (valid/ready handshake,
// operand and result buses).
interface p_div_if;
    logic        valid;
    logic        ready;
    logic        div_q;
    logic        div_r;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] result;

    modport master (
        output valid, div_q, div_r, pw, crs1, crs2,
        input  ready, result
    );

    modport slave (
        input  valid, div_q, div_r, pw, crs1, crs2,
        output ready, result
    );
endinterface

// File: rtl/p_div_sub.sv
// 32-bit packed subtractor: borrow chains restart at each lane LSB, and the
// lane's final no-borrow flag is replicated over every bit of that lane.
module p_div_sub
    import p_div_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  lane_e       lw,
    output logic [31:0] diff,
    output logic [31:0] no_borrow
);

    logic [5:0]  w_s;
    logic [31:0] lsb_s;
    logic [31:0] msb_s;
    logic [31:0] bout_s;
    logic        bin_s;
    logic        borrow_s;

    // Lane-segmented ripple-borrow subtract
    always_comb begin
        w_s      = lane_bits(lw);
        lsb_s    = lane_lsb_mask(w_s);
        msb_s    = lane_msb_mask(w_s);
        diff     = 32'd0;
        bout_s   = 32'd0;
        bin_s    = 1'b0;
        borrow_s = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bin_s     = lsb_s[i] ? 1'b0 : borrow_s;
            diff[i]   = a[i] ^ b[i] ^ bin_s;
            borrow_s  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin_s);
            bout_s[i] = borrow_s;
        end
        no_borrow = lane_spread(~bout_s & msb_s, w_s);
    end

endmodule

// File: rtl/p_div.sv
// Packed unsigned restoring divider: every lane of crs1 is divided by the
// matching lane of crs2, one quotient bit per cycle, all lanes in parallel.
module p_div
    import p_div_pkg::*;
(
    input  logic    clock,
    input  logic    resetn,
    p_div_if.slave  bus
);

    state_e      state_r;
    logic [5:0]  count_r;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic [31:0] d_r;
    lane_e       lw_r;
    logic        ready_r;

    logic [5:0]  w_s;
    logic [31:0] lsb_s;
    logic [31:0] msb_s;
    logic [31:0] r_sh_s;
    logic [31:0] q_sh_s;
    logic [31:0] carry_s;
    logic [31:0] diff_s;
    logic [31:0] no_borrow_s;
    logic [31:0] take_s;
    logic [31:0] r_nxt_s;
    logic [31:0] q_nxt_s;
    logic [31:0] result_s;

    // Lane-masked left shift of {R,Q}; each Q lane MSB drops into its R lane LSB
    always_comb begin
        w_s     = lane_bits(lw_r);
        lsb_s   = lane_lsb_mask(w_s);
        msb_s   = lane_msb_mask(w_s);
        r_sh_s  = ({r_r[30:0], 1'b0} & ~lsb_s) | ((q_r & msb_s) >> (w_s - 6'd1));
        q_sh_s  = {q_r[30:0], 1'b0} & ~lsb_s;
        // A bit shifted out of R means the partial remainder exceeds any divisor.
        carry_s = lane_spread(r_r & msb_s, w_s);
    end

    p_div_sub u_sub (
        .a         (r_sh_s),
        .b         (d_r),
        .lw        (lw_r),
        .diff      (diff_s),
        .no_borrow (no_borrow_s)
    );

    // Restore-or-keep selection and quotient bit insertion
    always_comb begin
        take_s  = no_borrow_s | carry_s;
        r_nxt_s = (take_s & diff_s) | (~take_s & r_sh_s);
        q_nxt_s = q_sh_s | (take_s & lsb_s);
    end

    // Handshake FSM, operand capture and iteration registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            count_r <= 6'd0;
            q_r     <= 32'd0;
            r_r     <= 32'd0;
            d_r     <= 32'd0;
            lw_r    <= LW_32;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.valid) begin
                        q_r     <= bus.crs1;
                        d_r     <= bus.crs2;
                        r_r     <= 32'd0;
                        count_r <= 6'd0;
                        lw_r    <= decode_pw(bus.pw);
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!bus.valid) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        q_r     <= q_nxt_s;
                        r_r     <= r_nxt_s;
                        count_r <= count_r + 6'd1;
                        if (count_r == (w_s - 6'd1)) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            ready_r <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    // Either a transfer or an abort: both return to IDLE.
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Result select; selectors are live while the result is presented
    always_comb begin
        result_s = 32'd0;
        if (state_r == ST_DONE) begin
            if (bus.div_q) begin
                result_s = q_r;
            end else if (bus.div_r) begin
                result_s = r_r;
            end else begin
                result_s = 32'd0;
            end
        end else begin
            result_s = 32'd0;
        end
    end

    assign bus.ready  = ready_r;
    assign bus.result = result_s;

endmodule

// File: tb/tb_p_div.sv
// Bench for p_div: directed vector table, abort and reset sequences, and
// randomised requests compared against a per-lane / and % model.
module tb_p_div;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    p_div_if bus();

    p_div dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  pw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Per-lane reference from plain integer division.
    function automatic void ref_div(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        int w;
        longint unsigned m, ai, bi, qi, ri, qa, ra;
        case (p)
            5'b00001: w = 32;
            5'b00010: w = 16;
            5'b00100: w = 8;
            5'b01000: w = 4;
            5'b10000: w = 2;
            default:  w = 32;
        endcase
        lat = w + 1;
        m   = (64'd1 << w) - 64'd1;
        qa  = 64'd0;
        ra  = 64'd0;
        for (int l = 0; l < 32 / w; l++) begin
            ai = ({32'd0, a} >> (l * w)) & m;
            bi = ({32'd0, b} >> (l * w)) & m;
            if (bi == 64'd0) begin
                qi = m;
                ri = ai;
            end else begin
                qi = ai / bi;
                ri = ai % bi;
            end
            qa = qa | (qi << (l * w));
            ra = ra | (ri << (l * w));
        end
        q = qa[31:0];
        r = ra[31:0];
    endfunction

    // Issue one request from a negedge, wait for ready, check latency and result.
    task automatic run_op(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat,
                          input bit chk_res, input string tag);
        int cyc;
        cyc = 0;
        bus.pw    = p;
        bus.crs1  = a;
        bus.crs2  = b;
        bus.valid = 1'b1;
        while (cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (bus.ready === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        if (bus.ready === 1'b1) begin
            if (chk_res) begin
                bus.div_q = 1'b1; bus.div_r = 1'b0; #1;
                check({tag, "_quot"}, bus.result, eq);
                bus.div_q = 1'b0; bus.div_r = 1'b1; #1;
                check({tag, "_rem"}, bus.result, er);
                bus.div_q = 1'b0; bus.div_r = 1'b0; #1;
                check({tag, "_nosel"}, bus.result, 32'd0);
            end
            @(negedge clock);
            check({tag, "_ready_low"}, {31'd0, bus.ready}, 32'd0);
        end else begin
            bus.valid = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        logic [4:0]  p;
        logic [31:0] a, b, eq, er;
        int          lat, hi, gap, cyc;

        checks = 0;
        errors = 0;
        vecs[0] = '{5'b00001, 32'd100,        32'd7,        32'd14,       32'd2,        33};
        vecs[1] = '{5'b00010, 32'h006400FF,   32'h00070010, 32'h000E000F, 32'h0002000F, 17};
        vecs[2] = '{5'b00100, 32'h12345678,   32'h01010000, 32'h1234FFFF, 32'h00005678, 9};
        vecs[3] = '{5'b10000, 32'hFFFFFFFF,   32'h55555555, 32'hFFFFFFFF, 32'd0,        3};
        vecs[4] = '{5'b00001, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        33};
        vecs[5] = '{5'b00010, 32'hFFFF0000,   32'h00FF0000, 32'h0101FFFF, 32'd0,        17};
        vecs[6] = '{5'b00001, 32'd5,          32'd9,        32'd0,        32'd5,        33};

        resetn    = 1'b0;
        bus.valid = 1'b0;
        bus.div_q = 1'b1;
        bus.div_r = 1'b0;
        bus.pw    = 5'b00001;
        bus.crs1  = 32'd0;
        bus.crs2  = 32'd0;
        repeat (2) @(negedge clock);
        check("reset_ready", {31'd0, bus.ready}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Directed table, issued back to back.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].pw, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat, 1'b1,
                   $sformatf("vec%0d", i));
        end
        bus.valid = 1'b0;
        @(negedge clock);

        // Abort: valid dropped in cycle 10 of a 32-bit op.
        bus.pw = 5'b00001; bus.crs1 = 32'd100; bus.crs2 = 32'd7; bus.valid = 1'b1;
        hi = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus.ready === 1'b1) hi++;
        end
        bus.valid = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.ready === 1'b1) hi++;
        end
        check("abort_ready_seen", 32'(hi), 32'd0);
        run_op(5'b01000, 32'h000000F9, 32'h00000013, 32'hFFFFFFF3, 32'd0, 5, 1'b1, "after_abort");
        bus.valid = 1'b0;
        @(negedge clock);

        // Reset in cycle 5 of a 32-bit op, then a clean op.
        bus.pw = 5'b00001; bus.crs1 = 32'd100; bus.crs2 = 32'd7; bus.valid = 1'b1;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        @(negedge clock);
        bus.valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_op(5'b00001, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1, "post_rst");
        bus.valid = 1'b0;
        @(negedge clock);

        // Reset while the result is being presented.
        bus.div_q = 1'b1; bus.div_r = 1'b0;
        bus.pw = 5'b10000; bus.crs1 = 32'hFFFFFFFF; bus.crs2 = 32'h55555555; bus.valid = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clock);
            cyc++;
            if (bus.ready === 1'b1) break;
        end
        check("done_rst_latency", 32'(cyc), 32'd3);
        #1;
        check("done_rst_before", bus.result, 32'hFFFFFFFF);
        resetn = 1'b0;
        #1;
        check("done_rst_ready", {31'd0, bus.ready}, 32'd0);
        check("done_rst_result", bus.result, 32'd0);
        @(negedge clock);
        bus.valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Randomised requests against the reference model.
        for (int n = 0; n < 1500; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                bus.valid = 1'b0;
                repeat (gap) @(negedge clock);
            end
            if ($urandom_range(0, 19) == 0) p = 5'($urandom);
            else p = 5'd1 << 3'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            bus.div_q = 1'($urandom);
            bus.div_r = 1'($urandom);
            ref_div(p, a, b, eq, er, lat);
            run_op(p, a, b, eq, er, lat, $onehot(p), $sformatf("rnd%0d_pw%b", n, p));
        end
        bus.valid = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
